// File: rtl/cndm_proto_dma_desc_arb.sv
// cndm_proto_dma_desc_arb
//
// Shares one DMA descriptor request/status channel among CNT requesters.
// Descriptors are granted round-robin from requesters that still have room
// under their outstanding-operation limit. Each forwarded descriptor is tagged
// with {requester index, requester tag}. Completion status coming back from
// the DMA engine is routed to the owning requester using the index bits of
// the completion tag.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   s_desc_*          per-requester descriptor input (valid/ready handshake)
//   m_desc_*          registered descriptor output to the DMA engine
//   s_sts_*           completion strobe from the DMA engine (no backpressure)
//   m_sts_*           per-requester routed completion, registered (latency 1)
//   busy              any requester has outstanding work or a descriptor is held
//   stat_err          one-cycle pulse on a completion for an idle requester
module cndm_proto_dma_desc_arb #(
  parameter int CNT             = 4,
  parameter int DESC_W          = 96,
  parameter int TAG_W           = 8,
  parameter int REQ_TAG_W       = TAG_W - $clog2(CNT),
  parameter int STS_W           = 4,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,

  input  logic [CNT*DESC_W-1:0]    s_desc_data,
  input  logic [CNT*REQ_TAG_W-1:0] s_desc_tag,
  input  logic [CNT-1:0]           s_desc_valid,
  output logic [CNT-1:0]           s_desc_ready,

  output logic [DESC_W-1:0]        m_desc_data,
  output logic [TAG_W-1:0]         m_desc_tag,
  output logic                     m_desc_valid,
  input  logic                     m_desc_ready,

  input  logic [TAG_W-1:0]         s_sts_tag,
  input  logic [STS_W-1:0]         s_sts_error,
  input  logic                     s_sts_valid,

  output logic [CNT*REQ_TAG_W-1:0] m_sts_tag,
  output logic [CNT*STS_W-1:0]     m_sts_error,
  output logic [CNT-1:0]           m_sts_valid,

  output logic                     busy,
  output logic                     stat_err
);

  localparam int IDX_W  = $clog2(CNT);
  localparam int OCNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [IDX_W-1:0]  ptr_reg;
  logic [OCNT_W-1:0] outstanding_reg [CNT];

  logic [CNT-1:0]    eligible;
  logic [CNT-1:0]    cnt_nonzero;
  logic [CNT-1:0]    cnt_inc;
  logic [CNT-1:0]    cnt_dec;
  logic [CNT-1:0]    sts_hit;
  logic [IDX_W-1:0]  sts_idx;
  logic              load_en;
  logic              grant_valid;
  logic [IDX_W-1:0]  grant_idx;
  logic [IDX_W-1:0]  cand_idx;

  assign sts_idx = s_sts_tag[TAG_W-1 -: IDX_W];
  assign load_en = !m_desc_valid || m_desc_ready;

  genvar gi;
  generate
    for (gi = 0; gi < CNT; gi++) begin : g_req
      assign eligible[gi]    = s_desc_valid[gi] &&
                               (outstanding_reg[gi] < OCNT_W'(MAX_OUTSTANDING));
      assign cnt_nonzero[gi] = (outstanding_reg[gi] != '0);
      assign sts_hit[gi]     = s_sts_valid && (sts_idx == IDX_W'(gi));
      assign cnt_inc[gi]     = s_desc_ready[gi];
      // A completion for an idle requester must not wrap its counter.
      assign cnt_dec[gi]     = sts_hit[gi] && cnt_nonzero[gi];
    end
  endgenerate

  // Scan from the round-robin pointer; the first eligible index wins.
  // CNT is a power of two, so index wrap is just truncation.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand_idx    = '0;
    for (int off = 0; off < CNT; off++) begin
      cand_idx = ptr_reg + IDX_W'(off);
      if (!grant_valid && eligible[cand_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  assign s_desc_ready = (load_en && grant_valid) ? (CNT'(1) << grant_idx) : '0;
  assign busy         = (|cnt_nonzero) || m_desc_valid;

  // Descriptor output register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_desc_valid <= 1'b0;
      m_desc_data  <= '0;
      m_desc_tag   <= '0;
      ptr_reg      <= '0;
    end else if (load_en) begin
      if (grant_valid) begin
        m_desc_valid <= 1'b1;
        m_desc_data  <= s_desc_data[grant_idx*DESC_W +: DESC_W];
        m_desc_tag   <= {grant_idx, s_desc_tag[grant_idx*REQ_TAG_W +: REQ_TAG_W]};
        ptr_reg      <= grant_idx + IDX_W'(1);
      end else begin
        // Payload is left as-is; only the valid flag drops.
        m_desc_valid <= 1'b0;
      end
    end
  end

  // Outstanding counters and routed completion lanes. Lane tag/error only
  // load on a hit so each lane keeps its last completion between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sts_valid <= '0;
      m_sts_tag   <= '0;
      m_sts_error <= '0;
      stat_err    <= 1'b0;
      for (int i = 0; i < CNT; i++) begin
        outstanding_reg[i] <= '0;
      end
    end else begin
      m_sts_valid <= sts_hit;
      stat_err    <= s_sts_valid && !cnt_nonzero[sts_idx];
      for (int i = 0; i < CNT; i++) begin
        if (sts_hit[i]) begin
          m_sts_tag[i*REQ_TAG_W +: REQ_TAG_W] <= s_sts_tag[REQ_TAG_W-1:0];
          m_sts_error[i*STS_W +: STS_W]       <= s_sts_error;
        end
        // Grant and completion in the same cycle cancel out.
        if (cnt_inc[i] && !cnt_dec[i]) begin
          outstanding_reg[i] <= outstanding_reg[i] + OCNT_W'(1);
        end else if (cnt_dec[i] && !cnt_inc[i]) begin
          outstanding_reg[i] <= outstanding_reg[i] - OCNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_cndm_proto_dma_desc_arb.sv
module tb_cndm_proto_dma_desc_arb;

  localparam int CNT    = 4;
  localparam int DESC_W = 96;
  localparam int TAG_W  = 8;
  localparam int RT     = 6;
  localparam int STS_W  = 4;
  localparam int MAXO   = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [CNT*DESC_W-1:0] s_desc_data;
  logic [CNT*RT-1:0]   s_desc_tag;
  logic [CNT-1:0]      s_desc_valid;
  logic [CNT-1:0]      s_desc_ready;
  logic [DESC_W-1:0]   m_desc_data;
  logic [TAG_W-1:0]    m_desc_tag;
  logic                m_desc_valid;
  logic                m_desc_ready;
  logic [TAG_W-1:0]    s_sts_tag;
  logic [STS_W-1:0]    s_sts_error;
  logic                s_sts_valid;
  logic [CNT*RT-1:0]   m_sts_tag;
  logic [CNT*STS_W-1:0] m_sts_error;
  logic [CNT-1:0]      m_sts_valid;
  logic                busy;
  logic                stat_err;

  always #5 clk = ~clk;

  cndm_proto_dma_desc_arb #(
    .CNT(CNT), .DESC_W(DESC_W), .TAG_W(TAG_W), .REQ_TAG_W(RT),
    .STS_W(STS_W), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_desc_data(s_desc_data), .s_desc_tag(s_desc_tag),
    .s_desc_valid(s_desc_valid), .s_desc_ready(s_desc_ready),
    .m_desc_data(m_desc_data), .m_desc_tag(m_desc_tag),
    .m_desc_valid(m_desc_valid), .m_desc_ready(m_desc_ready),
    .s_sts_tag(s_sts_tag), .s_sts_error(s_sts_error), .s_sts_valid(s_sts_valid),
    .m_sts_tag(m_sts_tag), .m_sts_error(m_sts_error), .m_sts_valid(m_sts_valid),
    .busy(busy), .stat_err(stat_err)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Reference model: the set of issued-but-uncompleted tags per requester,
  // the descriptor currently presented, and the expected completion lanes.
  bit          mv;
  logic [95:0] mdata;
  logic [7:0]  mtag;
  int          ptr;
  logic [3:0]  sv_exp;
  logic [5:0]  stag_exp [4];
  logic [3:0]  serr_exp [4];
  bit          staterr_exp;
  logic [5:0]  q [4][$];

  task automatic model_clear();
    mv = 0; mdata = '0; mtag = '0; ptr = 0; sv_exp = '0; staterr_exp = 0;
    for (int i = 0; i < CNT; i++) begin
      q[i].delete();
      stag_exp[i] = '0;
      serr_exp[i] = '0;
    end
  endtask

  task automatic idle_inputs();
    s_desc_data = '0; s_desc_tag = '0; s_desc_valid = '0; m_desc_ready = 1'b0;
    s_sts_tag = '0; s_sts_error = '0; s_sts_valid = 1'b0;
  endtask

  // Asserts reset asynchronously between edges, checks the immediate effect,
  // then releases it on a falling edge with all inputs idle.
  task automatic apply_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_m_desc_valid", m_desc_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_m_sts_valid", m_sts_valid, 4'b0);
    check("rst_stat_err", stat_err, 1'b0);
    check("rst_m_desc_tag", m_desc_tag, 8'h0);
    check("rst_m_sts_tag", m_sts_tag, 24'h0);
    idle_inputs();
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock cycle: check registered outputs, drive inputs, check the
  // combinational grant, and advance the model to the next edge.
  task automatic run_cycle(input logic [3:0] v, input logic [23:0] tags, input logic rdy,
                           input logic sv, input logic [7:0] st, input logic [3:0] se);
    logic [95:0] pay [4];
    int  g;
    bit  load;
    bit  b;
    int  k;
    @(negedge clk);
    check("m_desc_valid", m_desc_valid, mv);
    if (mv) begin
      check("m_desc_data", m_desc_data, mdata);
      check("m_desc_tag", m_desc_tag, mtag);
    end
    check("m_sts_valid", m_sts_valid, sv_exp);
    for (int i = 0; i < CNT; i++) begin
      if (sv_exp[i]) begin
        check("m_sts_tag", m_sts_tag[i*RT +: RT], stag_exp[i]);
        check("m_sts_error", m_sts_error[i*STS_W +: STS_W], serr_exp[i]);
      end
    end
    check("stat_err", stat_err, staterr_exp);
    b = mv;
    for (int i = 0; i < CNT; i++) if (q[i].size() > 0) b = 1;
    check("busy", busy, b);

    for (int i = 0; i < CNT; i++) begin
      pay[i] = {$urandom, $urandom, $urandom};
      s_desc_data[i*DESC_W +: DESC_W] = pay[i];
    end
    s_desc_tag   = tags;
    s_desc_valid = v;
    m_desc_ready = rdy;
    s_sts_valid  = sv;
    s_sts_tag    = st;
    s_sts_error  = se;
    #1;

    load = !mv || rdy;
    g = -1;
    if (load) begin
      for (int off = 0; off < CNT; off++) begin
        k = (ptr + off) % CNT;
        if (g < 0 && v[k] && q[k].size() < MAXO) g = k;
      end
    end
    check("s_desc_ready", s_desc_ready, (g >= 0) ? (4'b1 << g) : 4'b0);

    sv_exp = '0;
    staterr_exp = 0;
    if (sv) begin
      k = st[7:6];
      sv_exp[k] = 1'b1;
      stag_exp[k] = st[5:0];
      serr_exp[k] = se;
      if (q[k].size() == 0) staterr_exp = 1;
      else void'(q[k].pop_front());
    end
    if (g >= 0) begin
      q[g].push_back(tags[g*RT +: RT]);
      mv = 1;
      mdata = pay[g];
      mtag = {g[1:0], tags[g*RT +: RT]};
      ptr = (g + 1) % CNT;
    end else if (rdy) begin
      mv = 0;
    end
  endtask

  initial begin
    logic [3:0] rv;
    logic       rsv;
    logic [7:0] rst_tag;
    int         k;
    idle_inputs();
    model_clear();
    @(negedge clk);
    apply_reset();

    // Single request: requester 2, tag 0x15 -> tag 0x95.
    run_cycle(4'b0100, 24'h15 << 12, 1'b0, 1'b0, 8'h0, 4'h0);
    run_cycle(4'b0000, 24'h0, 1'b0, 1'b0, 8'h0, 4'h0);
    check("single_tag", m_desc_tag, 8'h95);
    check("single_busy", busy, 1'b1);

    // Fairness: all valid, engine always ready.
    @(negedge clk);
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      run_cycle(4'hf, $urandom, 1'b1, 1'b0, 8'h0, 4'h0);
      check("fair_grant", s_desc_ready, 4'b1 << (i % 4));
    end

    // Backpressure for 5 cycles, then release: requester 2 goes next.
    for (int i = 0; i < 5; i++) begin
      run_cycle(4'hf, $urandom, 1'b0, 1'b0, 8'h0, 4'h0);
      check("bp_ready", s_desc_ready, 4'b0);
    end
    run_cycle(4'hf, $urandom, 1'b1, 1'b0, 8'h0, 4'h0);
    check("bp_release", s_desc_ready, 4'b0100);

    // Limit: requester 0 alone takes exactly MAXO, then a completion frees it.
    @(negedge clk);
    apply_reset();
    run_cycle(4'b0001, $urandom, 1'b1, 1'b0, 8'h0, 4'h0);
    check("limit_1", s_desc_ready, 4'b0001);
    run_cycle(4'b0001, $urandom, 1'b1, 1'b0, 8'h0, 4'h0);
    check("limit_2", s_desc_ready, 4'b0001);
    run_cycle(4'b0001, $urandom, 1'b1, 1'b0, 8'h0, 4'h0);
    check("limit_full", s_desc_ready, 4'b0000);
    run_cycle(4'b0001, $urandom, 1'b1, 1'b1, 8'h03, 4'h0);
    check("limit_still_full", s_desc_ready, 4'b0000);
    run_cycle(4'b0001, $urandom, 1'b1, 1'b0, 8'h0, 4'h0);
    check("limit_sts_valid", m_sts_valid, 4'b0001);
    check("limit_sts_tag", m_sts_tag[5:0], 6'h03);
    check("limit_reopen", s_desc_ready, 4'b0001);

    // Grant and completion for requester 1 in the same cycle.
    @(negedge clk);
    apply_reset();
    run_cycle(4'b0010, $urandom, 1'b1, 1'b0, 8'h0, 4'h0);
    run_cycle(4'b0010, $urandom, 1'b1, 1'b1, 8'h41, 4'h5);
    check("simul_grant", s_desc_ready, 4'b0010);
    run_cycle(4'b0000, $urandom, 1'b1, 1'b0, 8'h0, 4'h0);
    check("simul_sts_valid", m_sts_valid, 4'b0010);
    check("simul_stat_err", stat_err, 1'b0);

    // Spurious completion on idle requester 3.
    @(negedge clk);
    apply_reset();
    run_cycle(4'b0000, $urandom, 1'b1, 1'b1, 8'hC0, 4'h2);
    run_cycle(4'b0000, $urandom, 1'b1, 1'b0, 8'h0, 4'h0);
    check("spur_stat_err", stat_err, 1'b1);
    check("spur_sts_valid", m_sts_valid, 4'b1000);
    check("spur_busy", busy, 1'b0);

    // Randomized traffic with occasional mid-burst resets.
    for (int c = 0; c < 3000; c++) begin
      rv  = 4'($urandom);
      rsv = ($urandom % 5) < 2;
      k   = $urandom % CNT;
      if (q[k].size() > 0 && ($urandom % 8) != 0) rst_tag = {2'(k), q[k][0]};
      else rst_tag = {2'(k), 6'($urandom)};
      run_cycle(rv, $urandom, ($urandom % 4) != 0, rsv, rst_tag, 4'($urandom));
      if (c % 700 == 699) apply_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cndm_proto_dma_desc_arb.md
Name: cndm_proto_dma_desc_arb

Overview:
- Shares one DMA descriptor request/status channel (read or write engine side) among CNT requesters, e.g. per-port TX/RX/descriptor-fetch queues.
- Round-robin arbitration with a per-requester outstanding-operation limit.
- Tags every forwarded descriptor with the requester index and routes returned completion status back to the originating requester by that tag.
- Sits between the core's queue managers and the host DMA interface engine.

Parameters:
CNT, 4, number of requesters (power of two, >=2)
DESC_W, 96, opaque descriptor payload width (addresses, sel, len), passed through unmodified
TAG_W, 8, tag width on the DMA engine side
REQ_TAG_W, TAG_W-$clog2(CNT), tag width on requester side
STS_W, 4, completion status/error field width
MAX_OUTSTANDING, 16, per-requester limit on issued-but-uncompleted descriptors (1..255)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
s_desc_data  in  CNT*DESC_W  requester descriptor payloads
s_desc_tag  in  CNT*REQ_TAG_W  requester tags
s_desc_valid  in  CNT  requester descriptor valid
s_desc_ready  out  CNT  requester descriptor accepted
m_desc_data  out  DESC_W  descriptor to DMA engine
m_desc_tag  out  TAG_W  {requester index, requester tag}
m_desc_valid  out  1  descriptor valid
m_desc_ready  in  1  DMA engine accepts
s_sts_tag  in  TAG_W  completion tag from DMA engine
s_sts_error  in  STS_W  completion status
s_sts_valid  in  1  completion strobe (no backpressure)
m_sts_tag  out  CNT*REQ_TAG_W  routed completion tag
m_sts_error  out  CNT*STS_W  routed completion status
m_sts_valid  out  CNT  routed completion strobe, one-hot or zero
busy  out  1  any requester has outstanding >0 or m_desc_valid
stat_err  out  1  one-cycle pulse on completion for requester with zero outstanding

Behaviour:
- Clocking: all state on posedge clk. rst_n low asynchronously clears every register: m_desc_valid=0, m_desc_data/tag=0, m_sts_valid=0, m_sts_tag/error=0, stat_err=0, all outstanding counters=0, round-robin pointer=0. busy=0 follows.
- Eligibility: requester i is eligible when s_desc_valid[i]=1 and outstanding[i] < MAX_OUTSTANDING.
- Load condition: output register may load when m_desc_valid=0 or m_desc_ready=1 (full throughput, one descriptor per cycle).
- Arbitration: when the output register can load, grant the first eligible requester at or after the pointer (wrapping index CNT-1 to 0). s_desc_ready is combinational: s_desc_ready[g]=1 only for the granted index in that cycle, else 0.
- On grant (next edge):
  - m_desc_data <= payload g; m_desc_tag <= {g, s_desc_tag[g]}; m_desc_valid <= 1.
  - pointer <= g+1 mod CNT; outstanding[g] increments.
- No eligible requester and m_desc_ready=1: m_desc_valid <= 0. While m_desc_valid=1 and m_desc_ready=0, m_desc_data and m_desc_tag are held stable.
- Requester at MAX_OUTSTANDING: skipped; its ready stays 0 until a completion decrements its counter.
- Status routing (registered, latency 1): on s_sts_valid, index k = s_sts_tag[TAG_W-1 -: $clog2(CNT)].
  - Next cycle: m_sts_valid[k]=1; m_sts_tag[k] = low REQ_TAG_W bits; m_sts_error[k] = s_sts_error.
  - m_sts_valid is 0 on all other cycles and indices. Non-zero error is forwarded and treated as a completion.
- Counter update: grant and completion for the same requester in the same cycle leave the counter unchanged.
- Completion with outstanding[k]=0: counter stays 0 (no underflow), status is still forwarded, and stat_err pulses for one cycle.
- busy is combinational from registered state.
- Reset mid-operation: all in-flight tracking is dropped. Completions arriving after reset for descriptors issued before it produce stat_err pulses.

Test Plan:
- Single request: requester 2 presents tag 0x15, CNT=4, TAG_W=8 -> next cycle m_desc_tag=0x95 with payload intact; outstanding[2]=1; busy=1.
- Fairness: all 4 valid continuously, m_desc_ready=1 -> grant order 0,1,2,3,0,1 on consecutive cycles; no bubbles.
- Backpressure: m_desc_ready=0 for 5 cycles with a descriptor loaded -> m_desc_data/tag stable; all s_desc_ready=0; on release, the next requester is issued the same cycle.
- Limit: MAX_OUTSTANDING=2, requester 0 alone valid, no completions -> exactly 2 accepted, then s_desc_ready[0]=0. A completion tag 0x03 -> m_sts_valid[0] pulses with tag 0x03, and the next descriptor is accepted.
- Simultaneous: requester 1 granted in the same cycle as completion tag 0x41 -> outstanding[1] unchanged; m_sts_valid=4'b0010 one cycle later.
- Spurious completion and reset: completion tag 0xC0 with outstanding[3]=0 -> stat_err pulse, m_sts_valid[3]=1, counter stays 0. Assert rst_n=0 mid-burst -> m_desc_valid=0 and busy=0 immediately (asynchronous).
